// File: rtl/sd_data_master_rr.sv
// SD data master: fetches a TX/RX buffer descriptor, issues the block command with retry,
// supervises the data phase under a watchdog, then sends CMD12 and posts sticky status.
module sd_data_master_rr #(
   parameter int RAM_MEM_WIDTH = 32,
   parameter int BD_WIDTH      = 5,
   parameter int BD_EMPTY      = 16,
   parameter int RETRY_MAX     = 3,
   parameter int TIMEOUT       = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [RAM_MEM_WIDTH-1:0] dat_in_tx,
   input  logic [RAM_MEM_WIDTH-1:0] dat_in_rx,
   input  logic [BD_WIDTH-1:0]      free_tx_bd,
   input  logic [BD_WIDTH-1:0]      free_rx_bd,
   output logic                     re_s_tx,
   output logic                     re_s_rx,
   input  logic                     ack_i_s_tx,
   input  logic                     ack_i_s_rx,
   output logic                     a_cmp_tx,
   output logic                     a_cmp_rx,
   input  logic                     cmd_busy,
   output logic                     we_req,
   input  logic                     we_ack,
   input  logic                     cmd_tsf_err,
   output logic [5:0]               cmd_idx,
   output logic [RAM_MEM_WIDTH-1:0] cmd_arg,
   input  logic [4:0]               card_status,
   output logic                     start_tx_fifo,
   output logic                     start_rx_fifo,
   output logic [RAM_MEM_WIDTH-1:0] sys_adr,
   input  logic                     tx_empt,
   input  logic                     tx_full,
   input  logic                     rx_full,
   output logic                     d_write,
   output logic                     d_read,
   input  logic                     busy_n,
   input  logic                     transm_complete,
   input  logic                     crc_ok,
   input  logic [1:0]               transfer_type,
   output logic [4:0]               Dat_Int_Status,
   input  logic                     Dat_Int_Status_rst,
   output logic                     CIDAT
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
   localparam logic [2:0]          RETRY_LIM  = 3'(RETRY_MAX);
   localparam logic [BD_WIDTH-1:0] BD_EMPTY_V = BD_WIDTH'(BD_EMPTY);

   typedef enum logic [2:0] {
      IDLE, GET_TX_BD, GET_RX_BD, SEND_CMD, RECIVE_CMD, DATA_TRANSFER, STOP, STOP_SEND
   } state_t;

   state_t state_reg, state_next;
   logic dir_tx_reg, dir_tx_next, last_tx_reg, last_tx_next;
   logic ack_cnt_reg, ack_cnt_next, err_reg, err_next, wrote_reg, wrote_next;
   logic [2:0] retry_reg, retry_next;
   logic [WD_W-1:0] wd_reg, wd_next;
   logic re_s_tx_reg, re_s_tx_next, re_s_rx_reg, re_s_rx_next;
   logic a_cmp_tx_reg, a_cmp_tx_next, a_cmp_rx_reg, a_cmp_rx_next;
   logic we_req_reg, we_req_next;
   logic [5:0] cmd_idx_reg, cmd_idx_next;
   logic [RAM_MEM_WIDTH-1:0] cmd_arg_reg, cmd_arg_next, sys_adr_reg, sys_adr_next;
   logic start_tx_reg, start_tx_next, start_rx_reg, start_rx_next;
   logic d_write_reg, d_write_next, d_read_reg, d_read_next;
   logic [4:0] status_reg, status_next, set_bits;

   logic tx_pend, rx_pend, tx_go, rx_go, bd_ack, fail;
   logic [RAM_MEM_WIDTH-1:0] bd_dat;
   logic unused_card_state;

   assign unused_card_state = ^card_status[4:1];

   // Only enabled, pending directions compete; ties go to the side not served last.
   assign tx_pend = (transfer_type == 2'b00 || transfer_type == 2'b01) && (free_tx_bd < BD_EMPTY_V);
   assign rx_pend = (transfer_type == 2'b00 || transfer_type == 2'b10) && (free_rx_bd < BD_EMPTY_V);
   assign tx_go   = tx_pend && (!rx_pend || !last_tx_reg);
   assign rx_go   = rx_pend && !tx_go;
   assign bd_ack  = dir_tx_reg ? ack_i_s_tx : ack_i_s_rx;
   assign bd_dat  = dir_tx_reg ? dat_in_tx : dat_in_rx;
   assign fail    = err_reg || cmd_tsf_err || !card_status[0];

   always_comb begin
      state_next    = state_reg;
      dir_tx_next   = dir_tx_reg;
      last_tx_next  = last_tx_reg;
      ack_cnt_next  = ack_cnt_reg;
      err_next      = err_reg;
      wrote_next    = wrote_reg;
      retry_next    = retry_reg;
      wd_next       = wd_reg;
      re_s_tx_next  = re_s_tx_reg;
      re_s_rx_next  = re_s_rx_reg;
      a_cmp_tx_next = 1'b0;
      a_cmp_rx_next = 1'b0;
      we_req_next   = we_req_reg;
      cmd_idx_next  = cmd_idx_reg;
      cmd_arg_next  = cmd_arg_reg;
      sys_adr_next  = sys_adr_reg;
      start_tx_next = start_tx_reg;
      start_rx_next = start_rx_reg;
      d_write_next  = 1'b0;
      d_read_next   = 1'b0;
      set_bits      = '0;
      case (state_reg)
         IDLE: begin
            if (tx_go || rx_go) begin
               state_next   = tx_go ? GET_TX_BD : GET_RX_BD;
               dir_tx_next  = tx_go;
               re_s_tx_next = tx_go;
               re_s_rx_next = !tx_go;
               ack_cnt_next = 1'b0;
            end
         end
         GET_TX_BD, GET_RX_BD: begin
            if (bd_ack) begin
               if (!ack_cnt_reg) begin
                  sys_adr_next = bd_dat;
                  ack_cnt_next = 1'b1;
               end else begin
                  cmd_arg_next  = bd_dat;
                  cmd_idx_next  = dir_tx_reg ? 6'd24 : 6'd17;
                  start_tx_next = dir_tx_reg;
                  start_rx_next = !dir_tx_reg;
                  re_s_tx_next  = 1'b0;
                  re_s_rx_next  = 1'b0;
                  retry_next    = 3'd1;
                  err_next      = 1'b0;
                  we_req_next   = 1'b0;
                  state_next    = SEND_CMD;
               end
            end
         end
         SEND_CMD, STOP: begin
            // An error flagged alongside we_ack still counts against this attempt.
            if (state_reg == SEND_CMD && cmd_tsf_err) err_next = 1'b1;
            if (!we_req_reg) begin
               if (!cmd_busy) we_req_next = 1'b1;
            end else if (we_ack) begin
               we_req_next = 1'b0;
               state_next  = (state_reg == SEND_CMD) ? RECIVE_CMD : STOP_SEND;
            end
         end
         RECIVE_CMD: begin
            if (cmd_tsf_err) err_next = 1'b1;
            if (!cmd_busy) begin
               if (!fail) begin
                  state_next  = DATA_TRANSFER;
                  wd_next     = '0;
                  wrote_next  = 1'b0;
                  d_read_next = !dir_tx_reg;
               end else if (retry_reg < RETRY_LIM) begin
                  retry_next = retry_reg + 3'd1;
                  err_next   = 1'b0;
                  state_next = SEND_CMD;
               end else begin
                  set_bits[3]  = 1'b1;
                  cmd_idx_next = 6'd12;
                  cmd_arg_next = '0;
                  state_next   = STOP;
               end
            end
         end
         DATA_TRANSFER: begin
            wd_next = wd_reg + 1'b1;
            if (dir_tx_reg && !wrote_reg && tx_full) begin
               d_write_next = 1'b1;
               wrote_next   = 1'b1;
            end
            if (transm_complete) begin
               set_bits[0]  = 1'b1;
               set_bits[1]  = !crc_ok;
               cmd_idx_next = 6'd12;
               cmd_arg_next = '0;
               state_next   = STOP;
            end else begin
               if ((dir_tx_reg && wrote_reg && tx_empt) || (!dir_tx_reg && rx_full))
                  set_bits[2] = 1'b1;
               if (wd_reg == WD_LAST) begin
                  set_bits[4]  = 1'b1;
                  cmd_idx_next = 6'd12;
                  cmd_arg_next = '0;
                  state_next   = STOP;
               end
            end
         end
         STOP_SEND: begin
            if (!cmd_busy && busy_n) begin
               a_cmp_tx_next = dir_tx_reg;
               a_cmp_rx_next = !dir_tx_reg;
               last_tx_next  = dir_tx_reg;
               start_tx_next = 1'b0;
               start_rx_next = 1'b0;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      status_next = (Dat_Int_Status_rst ? 5'b00000 : status_reg) | set_bits;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         dir_tx_reg   <= 1'b0;
         last_tx_reg  <= 1'b0;
         ack_cnt_reg  <= 1'b0;
         err_reg      <= 1'b0;
         wrote_reg    <= 1'b0;
         retry_reg    <= '0;
         wd_reg       <= '0;
         re_s_tx_reg  <= 1'b0;
         re_s_rx_reg  <= 1'b0;
         a_cmp_tx_reg <= 1'b0;
         a_cmp_rx_reg <= 1'b0;
         we_req_reg   <= 1'b0;
         cmd_idx_reg  <= '0;
         cmd_arg_reg  <= '0;
         sys_adr_reg  <= '0;
         start_tx_reg <= 1'b0;
         start_rx_reg <= 1'b0;
         d_write_reg  <= 1'b0;
         d_read_reg   <= 1'b0;
         status_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         dir_tx_reg   <= dir_tx_next;
         last_tx_reg  <= last_tx_next;
         ack_cnt_reg  <= ack_cnt_next;
         err_reg      <= err_next;
         wrote_reg    <= wrote_next;
         retry_reg    <= retry_next;
         wd_reg       <= wd_next;
         re_s_tx_reg  <= re_s_tx_next;
         re_s_rx_reg  <= re_s_rx_next;
         a_cmp_tx_reg <= a_cmp_tx_next;
         a_cmp_rx_reg <= a_cmp_rx_next;
         we_req_reg   <= we_req_next;
         cmd_idx_reg  <= cmd_idx_next;
         cmd_arg_reg  <= cmd_arg_next;
         sys_adr_reg  <= sys_adr_next;
         start_tx_reg <= start_tx_next;
         start_rx_reg <= start_rx_next;
         d_write_reg  <= d_write_next;
         d_read_reg   <= d_read_next;
         status_reg   <= status_next;
      end
   end

   assign re_s_tx        = re_s_tx_reg;
   assign re_s_rx        = re_s_rx_reg;
   assign a_cmp_tx       = a_cmp_tx_reg;
   assign a_cmp_rx       = a_cmp_rx_reg;
   assign we_req         = we_req_reg;
   assign cmd_idx        = cmd_idx_reg;
   assign cmd_arg        = cmd_arg_reg;
   assign sys_adr        = sys_adr_reg;
   assign start_tx_fifo  = start_tx_reg;
   assign start_rx_fifo  = start_rx_reg;
   assign d_write        = d_write_reg;
   assign d_read         = d_read_reg;
   assign Dat_Int_Status = status_reg;
   assign CIDAT          = (state_reg != IDLE);

endmodule

// File: tb/tb_sd_data_master_rr.sv
// Directed bench for sd_data_master_rr: nominal RX, round-robin, retry, watchdog,
// CRC/status clear and mid-transfer reset.
module tb_sd_data_master_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dat_in_tx, dat_in_rx;
   logic [4:0]  free_tx_bd, free_rx_bd;
   logic        re_s_tx, re_s_rx, ack_i_s_tx, ack_i_s_rx, a_cmp_tx, a_cmp_rx;
   logic        cmd_busy, we_req, we_ack, cmd_tsf_err;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg, sys_adr;
   logic [4:0]  card_status;
   logic        start_tx_fifo, start_rx_fifo, tx_empt, tx_full, rx_full;
   logic        d_write, d_read, busy_n, transm_complete, crc_ok;
   logic [1:0]  transfer_type;
   logic [4:0]  Dat_Int_Status;
   logic        Dat_Int_Status_rst, CIDAT;

   int checks = 0;
   int errors = 0;
   int n_d_read = 0, n_d_write = 0, n_acmp_tx = 0, n_acmp_rx = 0;
   logic [5:0] cmd_log[$];
   logic we_req_q = 1'b0;

   always #5 clk = ~clk;

   sd_data_master_rr #(.TIMEOUT(16), .RETRY_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .dat_in_tx(dat_in_tx), .dat_in_rx(dat_in_rx),
      .free_tx_bd(free_tx_bd), .free_rx_bd(free_rx_bd),
      .re_s_tx(re_s_tx), .re_s_rx(re_s_rx),
      .ack_i_s_tx(ack_i_s_tx), .ack_i_s_rx(ack_i_s_rx),
      .a_cmp_tx(a_cmp_tx), .a_cmp_rx(a_cmp_rx),
      .cmd_busy(cmd_busy), .we_req(we_req), .we_ack(we_ack), .cmd_tsf_err(cmd_tsf_err),
      .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .card_status(card_status),
      .start_tx_fifo(start_tx_fifo), .start_rx_fifo(start_rx_fifo), .sys_adr(sys_adr),
      .tx_empt(tx_empt), .tx_full(tx_full), .rx_full(rx_full),
      .d_write(d_write), .d_read(d_read),
      .busy_n(busy_n), .transm_complete(transm_complete), .crc_ok(crc_ok),
      .transfer_type(transfer_type), .Dat_Int_Status(Dat_Int_Status),
      .Dat_Int_Status_rst(Dat_Int_Status_rst), .CIDAT(CIDAT)
   );

   // Pulse counters and command log, sampled on the falling edge.
   always @(negedge clk) begin
      if (d_read)   n_d_read  <= n_d_read + 1;
      if (d_write)  n_d_write <= n_d_write + 1;
      if (a_cmp_tx) n_acmp_tx <= n_acmp_tx + 1;
      if (a_cmp_rx) n_acmp_rx <= n_acmp_rx + 1;
      if (we_req && !we_req_q) cmd_log.push_back(cmd_idx);
      we_req_q <= we_req;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] out_pack();
      return {re_s_tx, re_s_rx, a_cmp_tx, a_cmp_rx, we_req, cmd_idx, start_tx_fifo,
              start_rx_fifo, d_write, d_read, Dat_Int_Status, CIDAT};
   endfunction

   task automatic do_reset();
      free_tx_bd = 5'd16; free_rx_bd = 5'd16; transfer_type = 2'b00;
      ack_i_s_tx = 0; ack_i_s_rx = 0; dat_in_tx = '0; dat_in_rx = '0;
      cmd_busy = 0; we_ack = 0; cmd_tsf_err = 0; card_status = 5'b01001;
      tx_empt = 0; tx_full = 0; rx_full = 0; busy_n = 1; transm_complete = 0; crc_ok = 1;
      Dat_Int_Status_rst = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic wait_we_req(input string tag);
      int n = 0;
      while (we_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (we_req !== 1'b1) check({tag, "_we_req_wait"}, we_req, 1);
   endtask

   task automatic ack_cmd(input string tag, input logic err);
      we_ack = 1; cmd_tsf_err = err;
      tick();
      we_ack = 0; cmd_tsf_err = 0;
      check({tag, "_we_req_fall"}, we_req, 0);
   endtask

   task automatic grant_fetch(input string tag, input logic tx, input logic [31:0] w0,
                              input logic [31:0] w1);
      tick();
      check({tag, "_grant"}, {re_s_tx, re_s_rx}, tx ? 2'b10 : 2'b01);
      if (tx) begin ack_i_s_tx = 1; dat_in_tx = w0; end
      else    begin ack_i_s_rx = 1; dat_in_rx = w0; end
      tick();
      check({tag, "_sys_adr"}, sys_adr, w0);
      if (tx) dat_in_tx = w1; else dat_in_rx = w1;
      tick();
      ack_i_s_tx = 0; ack_i_s_rx = 0;
      check({tag, "_cmd_arg"}, cmd_arg, w1);
      check({tag, "_cmd_idx"}, cmd_idx, tx ? 6'd24 : 6'd17);
      check({tag, "_fifo_re_wereq"}, {start_tx_fifo, start_rx_fifo, re_s_tx, re_s_rx, we_req},
            tx ? 5'b10000 : 5'b01000);
   endtask

   task automatic stop_phase(input string tag, input logic tx);
      wait_we_req({tag, "_stop"});
      check({tag, "_cmd12"}, {cmd_idx, cmd_arg}, {6'd12, 32'd0});
      ack_cmd({tag, "_stop"}, 0);
      tick();
      check({tag, "_a_cmp"}, {a_cmp_tx, a_cmp_rx, CIDAT}, tx ? 3'b100 : 3'b010);
   endtask

   task automatic xfer(input string tag, input logic tx, input logic crc, input logic clr,
                       input logic [31:0] w0, input logic [31:0] w1);
      int rd0, wr0;
      rd0 = n_d_read; wr0 = n_d_write;
      grant_fetch(tag, tx, w0, w1);
      wait_we_req(tag);
      ack_cmd(tag, 0);
      tick();
      check({tag, "_in_data"}, CIDAT, 1);
      if (tx) begin
         tx_full = 1;
         tick();
         tx_full = 0;
         check({tag, "_d_write"}, d_write, 1);
      end
      transm_complete = 1; crc_ok = crc; Dat_Int_Status_rst = clr;
      tick();
      transm_complete = 0; crc_ok = 1; Dat_Int_Status_rst = 0;
      stop_phase(tag, tx);
      check({tag, "_d_read_cnt"}, n_d_read - rd0, tx ? 0 : 1);
      check({tag, "_d_write_cnt"}, n_d_write - wr0, tx ? 1 : 0);
      $display("xfer %s dir=%s status=%05b", tag, tx ? "TX" : "RX", Dat_Int_Status);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int st, ar, at;

      // Reset state
      do_reset();
      check("reset_outputs", out_pack(), 21'd0);
      check("reset_buses", {sys_adr, cmd_arg}, 64'd0);

      // RX nominal
      st = cmd_log.size(); ar = n_acmp_rx;
      free_rx_bd = 5'd15;
      xfer("rx_nom", 0, 1, 0, 32'h1000, 32'h20);
      free_rx_bd = 5'd16;
      tick();
      check("rx_nom_status", Dat_Int_Status, 5'b00001);
      check("rx_nom_ncmd", cmd_log.size() - st, 2);
      check("rx_nom_cmd0", cmd_log[st], 6'd17);
      check("rx_nom_cmd1", cmd_log[st+1], 6'd12);
      check("rx_nom_acmp_cnt", n_acmp_rx - ar, 1);
      check("rx_nom_idle", {CIDAT, start_rx_fifo}, 2'b00);

      // Round-robin, then RX-only mode, then hold mode
      do_reset();
      at = n_acmp_tx; ar = n_acmp_rx;
      free_tx_bd = 5'd15; free_rx_bd = 5'd15;
      xfer("rr1_tx", 1, 1, 0, 32'hA000, 32'h1);
      xfer("rr2_rx", 0, 1, 0, 32'hB000, 32'h2);
      xfer("rr3_tx", 1, 1, 0, 32'hC000, 32'h3);
      transfer_type = 2'b10;
      xfer("rr4_rxonly", 0, 1, 0, 32'hD000, 32'h4);
      xfer("rr5_rxonly", 0, 1, 0, 32'hE000, 32'h5);
      transfer_type = 2'b11;
      repeat (3) tick();
      check("rr_hold_idle", {CIDAT, re_s_tx, re_s_rx}, 3'b000);
      free_tx_bd = 5'd16; free_rx_bd = 5'd16;
      check("rr_acmp_tx_cnt", n_acmp_tx - at, 2);
      check("rr_acmp_rx_cnt", n_acmp_rx - ar, 3);

      // Retry exhaustion
      do_reset();
      st = cmd_log.size(); at = n_acmp_tx;
      free_tx_bd = 5'd15;
      grant_fetch("rty", 1, 32'h5000, 32'h77);
      for (int i = 0; i < 3; i++) begin
         wait_we_req("rty");
         ack_cmd("rty", 1);
      end
      free_tx_bd = 5'd16;
      stop_phase("rty", 1);
      tick();
      check("rty_ncmd", cmd_log.size() - st, 4);
      check("rty_cmds", {cmd_log[st], cmd_log[st+1], cmd_log[st+2], cmd_log[st+3]},
            {6'd24, 6'd24, 6'd24, 6'd12});
      check("rty_status", Dat_Int_Status, 5'b01000);
      check("rty_acmp_cnt", n_acmp_tx - at, 1);
      $display("xfer rty dir=TX status=%05b", Dat_Int_Status);

      // Watchdog timeout
      do_reset();
      free_rx_bd = 5'd15;
      grant_fetch("tmo", 0, 32'h6000, 32'h8);
      wait_we_req("tmo");
      ack_cmd("tmo", 0);
      tick();
      free_rx_bd = 5'd16;
      repeat (15) tick();
      check("tmo_before", {CIDAT, Dat_Int_Status}, 6'b100000);
      tick();
      check("tmo_at16", Dat_Int_Status, 5'b10000);
      stop_phase("tmo", 0);
      $display("xfer tmo dir=RX status=%05b", Dat_Int_Status);

      // CRC error, clear, and clear coinciding with a new set
      do_reset();
      free_rx_bd = 5'd15;
      xfer("crc_bad", 0, 0, 0, 32'h7000, 32'h9);
      check("crc_bad_status", Dat_Int_Status, 5'b00011);
      free_rx_bd = 5'd16;
      Dat_Int_Status_rst = 1;
      tick();
      Dat_Int_Status_rst = 0;
      check("crc_clear", Dat_Int_Status, 5'b00000);
      free_rx_bd = 5'd15;
      xfer("crc_bad2", 0, 0, 0, 32'h7100, 32'hA);
      check("crc_bad2_status", Dat_Int_Status, 5'b00011);
      xfer("crc_clr_set", 0, 1, 1, 32'h7200, 32'hB);
      check("crc_clr_set_status", Dat_Int_Status, 5'b00001);
      free_rx_bd = 5'd16;

      // Mid-transfer reset
      do_reset();
      free_rx_bd = 5'd15;
      grant_fetch("mrst", 0, 32'h8000, 32'hC);
      wait_we_req("mrst");
      ack_cmd("mrst", 0);
      tick();
      check("mrst_in_data", {CIDAT, d_read}, 2'b11);
      free_rx_bd = 5'd16;
      at = n_acmp_tx; ar = n_acmp_rx;
      rst = 1;
      tick();
      check("mrst_outputs", out_pack(), 21'd0);
      check("mrst_buses", {sys_adr, cmd_arg}, 64'd0);
      rst = 0;
      repeat (5) tick();
      check("mrst_no_acmp", (n_acmp_tx - at) + (n_acmp_rx - ar), 0);
      check("mrst_idle", CIDAT, 0);
      $display("xfer mrst dir=RX aborted");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_data_master_rr.md
# sd_data_master_rr

Parametrised next-generation SD data master; sits between the TX/RX buffer-descriptor (BD) RAMs, the command master, and the data serial host. It fetches a BD, issues the block read or write command, and supervises the data phase. It then sends CMD12 and posts interrupt status. Compared with the previous master it adds:
- round-robin TX/RX arbitration;
- bounded command retry;
- a data-phase watchdog;
- a transfer-direction mode input.

## Interface
Parameters:
- RAM_MEM_WIDTH, 32: BD word width; also sys_adr and cmd_arg width.
- BD_WIDTH, 5: width of the free-BD counters.
- BD_EMPTY, 16: free-count value meaning no BD is pending. A direction is pending when its free count is below BD_EMPTY.
- RETRY_MAX, 3: maximum command attempts per BD, range 1..7.
- TIMEOUT, 4096: data-phase watchdog limit, in cycles.

Ports:
- clk in 1: the single clock.
- rst in 1: reset, synchronous and active-high.
- dat_in_tx / dat_in_rx in RAM_MEM_WIDTH: BD words.
- free_tx_bd / free_rx_bd in BD_WIDTH: free-BD counts.
- re_s_tx / re_s_rx out 1: BD read request.
- ack_i_s_tx / ack_i_s_rx in 1: BD word valid.
- a_cmp_tx / a_cmp_rx out 1: BD consumed pulse.
- cmd_busy in 1: command master busy.
- we_req out 1: command request.
- we_ack in 1: command accepted.
- cmd_tsf_err in 1: command transfer error.
- cmd_idx out 6: command index.
- cmd_arg out RAM_MEM_WIDTH: command argument.
- card_status in 5: bits [4:1] are the card state; bit [0] is READY_FOR_DATA.
- start_tx_fifo / start_rx_fifo out 1: FIFO enable.
- sys_adr out RAM_MEM_WIDTH: DMA system address.
- tx_empt, tx_full, rx_full in 1: FIFO flags.
- d_write / d_read out 1: start pulses to the data host.
- busy_n, transm_complete, crc_ok in 1: data-host status.
- transfer_type in 2: direction mode.
  - 00: auto round-robin.
  - 01: TX only.
  - 10: RX only.
  - 11: hold in IDLE.
- Dat_Int_Status out 5: sticky status bits.
  - [0]: transfer done.
  - [1]: CRC error.
  - [2]: FIFO under/overrun.
  - [3]: command failure.
  - [4]: timeout.
- Dat_Int_Status_rst in 1: clear all status bits.
- CIDAT out 1: high in every state except IDLE.

## Operation
- **Reset values:** all outputs 0, state IDLE. The retry counter, watchdog and round-robin pointer are cleared; the pointer favours TX first. A reset mid-operation aborts at the next edge and produces no a_cmp pulse.
- **States:** IDLE, GET_TX_BD, GET_RX_BD, SEND_CMD, RECIVE_CMD, DATA_TRANSFER, STOP, STOP_SEND.
- **IDLE arbitration:** only enabled, pending directions compete.
  - If both TX and RX are pending in mode 00, the direction not served last wins.
  - Otherwise the single pending direction wins.
- **GET_x_BD:** holds re_s_x high.
  - First ack latches sys_adr. Second ack latches cmd_arg, drops re_s_x, and moves to SEND_CMD.
  - cmd_idx becomes 24 for TX or 17 for RX.
  - The retry counter is set to 1.
  - start_tx_fifo or start_rx_fifo is asserted and held until the return to IDLE.
- **SEND_CMD:** waits for cmd_busy=0, then raises we_req. we_req holds until we_ack is sampled, then goes to RECIVE_CMD.
- **RECIVE_CMD:** waits for cmd_busy=0, then resolves:
  - If cmd_tsf_err was seen since SEND_CMD, or card_status[0]=0, the attempt has failed.
  - On failure with retry < RETRY_MAX: increment retry, go to SEND_CMD.
  - On failure with retry = RETRY_MAX: set status[3], go to STOP.
  - Otherwise go to DATA_TRANSFER.
- **DATA_TRANSFER:**
  - TX issues a d_write pulse once tx_full=1. RX issues a d_read pulse on entry.
  - The watchdog counts from 0 on entry.
  - On transm_complete: set status[0], and set status[1] if crc_ok=0, then go to STOP.
  - If the watchdog reaches TIMEOUT-1 first: set status[4], go to STOP.
  - Status[2] is set when either of these occurs before transm_complete:
    - tx_empt=1 (TX, after d_write);
    - rx_full=1 (RX).
- **STOP:** sends cmd_idx=12 with cmd_arg=0, using the same we_req handshake.
- **STOP_SEND:** waits for cmd_busy=0 and busy_n=1. Then pulses a_cmp for the served direction, records that direction in the round-robin pointer, and returns to IDLE.
- **Status register:** bits are sticky. Dat_Int_Status_rst clears all bits; a set in the same cycle wins.

## Timing
- Every state transition takes effect at the clk edge on which its condition is sampled.
- **BD fetch:** minimum 2 cycles after the grant, one per ack.
- **we_req:** rises 1 cycle after the state is entered with cmd_busy=0. It falls on the edge after we_ack is sampled high.
- **Pulses:** d_write, d_read and a_cmp_x are exactly 1 cycle wide.
- **Watchdog:** TIMEOUT cycles from DATA_TRANSFER entry to the status[4] set, inclusive.
- **FIFO start:** start_x_fifo rises on the same edge as the cmd_idx load.
- **Simultaneous events:**
  - transm_complete and watchdog expiry in the same cycle: status[0] is set and status[4] is not.
  - we_ack and cmd_tsf_err in the same cycle: counted as an error.

## Test plan
- **RX nominal:** free_rx_bd=BD_EMPTY-1, ack pair with words 0x1000 / 0x20, we_ack, card_status=5'b01001, transm_complete with crc_ok=1, busy_n=1 → expect:
  - cmd_idx 17 then 12, sys_adr=0x1000, cmd_arg=0x20;
  - one d_read pulse, one a_cmp_rx pulse;
  - status=5'b00001.
- **Round-robin:** both directions pending in mode 00 → grants alternate TX, RX, TX; mode 10 → RX only.
- **Retry exhaustion:** RETRY_MAX=3 with cmd_tsf_err on every attempt → exactly three CMD24 requests, then CMD12, status[3]=1, a_cmp_tx pulse.
- **Timeout:** TIMEOUT=16 with transm_complete held low → status[4] set on the 16th DATA_TRANSFER cycle; CMD12 still issued.
- **CRC error and clear:** transm_complete with crc_ok=0 → status=5'b00011. A Dat_Int_Status_rst pulse then gives 0; if it coincides with a new set, the set bit survives.
- **Mid-transfer reset:** rst in DATA_TRANSFER → next edge all outputs 0, state IDLE, no a_cmp pulse.
